// File: rtl/pulse_sequencer_pkg.sv
// Shared types for the pulse sequencer: FSM state encoding.
package pulse_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter; expired is combinational from the registered count (count==0).
// Holds at zero until the next load; load has priority over enable.
module load_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Runtime-programmable pulse-train generator: delay, then N pulses of width/gap, selectable polarity.
// All outputs registered; start accepted only when idle and not busy, abort wins over everything.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cfg_delay,
  input  logic [CNT_WIDTH-1:0] cfg_width,
  input  logic [CNT_WIDTH-1:0] cfg_gap,
  input  logic [REP_WIDTH-1:0] cfg_repeat,
  input  logic                 cfg_polarity,
  output logic                 pulse,
  output logic                 busy,
  output logic                 done,
  output logic [REP_WIDTH-1:0] pulse_index
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REP_WIDTH-1:0] REP_ONE = {{(REP_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  state_t               state_d;
  logic                 accept;
  logic                 inc_index;
  logic                 final_pulse;
  logic                 cnt_load;
  logic                 cnt_expired;
  logic [CNT_WIDTH-1:0] cnt_value;
  logic [CNT_WIDTH-1:0] width_sel;
  logic [CNT_WIDTH-1:0] width_q;
  logic [CNT_WIDTH-1:0] gap_q;
  logic [REP_WIDTH-1:0] repeat_q;
  logic                 polarity_q;
  logic                 polarity_next;

  // Phase length minus one, with a zero length behaving as one cycle.
  function automatic logic [CNT_WIDTH-1:0] phase_load(input logic [CNT_WIDTH-1:0] len);
    return (len == '0) ? '0 : len - CNT_ONE;
  endfunction

  assign final_pulse = (repeat_q != '0) && (pulse_index == repeat_q - REP_ONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    inc_index = 1'b0;
    case (state)
      ST_IDLE: begin
        // busy is still high on the edge that raises done; starts there are dropped
        if (start && !busy) begin
          accept  = 1'b1;
          state_d = (cfg_delay != '0) ? ST_DELAY : ST_ACTIVE;
        end
      end
      ST_DELAY: begin
        if (cnt_expired) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (cnt_expired) state_d = final_pulse ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (cnt_expired) begin
          state_d   = ST_ACTIVE;
          inc_index = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      accept    = 1'b0;
      inc_index = 1'b0;
    end
  end

  // One counter serves every phase; it is reloaded whenever the state changes.
  always_comb begin
    cnt_load      = (state_d != state);
    width_sel     = accept ? cfg_width : width_q;
    polarity_next = accept ? cfg_polarity : polarity_q;
    case (state_d)
      ST_DELAY:  cnt_value = cfg_delay - CNT_ONE;
      ST_ACTIVE: cnt_value = phase_load(width_sel);
      ST_GAP:    cnt_value = phase_load(gap_q);
      default:   cnt_value = '0;
    endcase
  end

  load_down_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_phase_cnt (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_value),
    .enable     (1'b1),
    .expired    (cnt_expired)
  );

  // Outputs trail the state by one edge, except abort which clears them on its own edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pulse_index <= '0;
      polarity_q  <= 1'b1;
      width_q     <= '0;
      gap_q       <= '0;
      repeat_q    <= '0;
    end else begin
      pulse <= ((state == ST_ACTIVE) && !abort) ? polarity_q : ~polarity_next;
      busy  <= !abort && (state != ST_IDLE);
      done  <= !abort && (state == ST_IDLE) && busy;
      if (accept) begin
        polarity_q  <= cfg_polarity;
        width_q     <= cfg_width;
        gap_q       <= cfg_gap;
        repeat_q    <= cfg_repeat;
        pulse_index <= '0;
      end else if (inc_index) begin
        pulse_index <= pulse_index + REP_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: timing, clamps, polarity, abort, ignored starts, async reset.
module tb_pulse_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_width;
  logic [15:0] cfg_gap;
  logic [7:0]  cfg_repeat;
  logic        cfg_polarity;
  logic        pulse;
  logic        busy;
  logic        done;
  logic [7:0]  pulse_index;

  int tests = 0;
  int fails = 0;

  logic       exp_p;
  logic       exp_b;
  logic       exp_d;
  logic [7:0] exp_i;

  pulse_sequencer #(
    .CNT_WIDTH(16),
    .REP_WIDTH(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_delay    (cfg_delay),
    .cfg_width    (cfg_width),
    .cfg_gap      (cfg_gap),
    .cfg_repeat   (cfg_repeat),
    .cfg_polarity (cfg_polarity),
    .pulse        (pulse),
    .busy         (busy),
    .done         (done),
    .pulse_index  (pulse_index)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] d, input logic [15:0] w, input logic [15:0] g,
                         input logic [7:0] n, input logic pol);
    cfg_delay    = d;
    cfg_width    = w;
    cfg_gap      = g;
    cfg_repeat   = n;
    cfg_polarity = pol;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(16'd0, 16'd0, 16'd0, 8'd0, 1'b1);
    #2;
    chk("rst.pulse", pulse, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.index", pulse_index, 0);
    #10 reset = 1'b0;

    // Idle with no start
    for (int n = 0; n < 20; n++) begin
      tick();
      chk($sformatf("idle%0d", n), {pulse, busy, done, pulse_index}, 0);
    end

    // Basic train D=3 W=2 G=4 N=3 active-high, started at relative edge 0.
    // Config is then changed to D=0 W=0 G=0 N=2 active-low, which only the second start may use.
    set_cfg(16'd3, 16'd2, 16'd4, 8'd3, 1'b1);
    start = 1'b1;
    tick();
    set_cfg(16'd0, 16'd0, 16'd0, 8'd2, 1'b0);
    for (int n = 1; n <= 30; n++) begin
      start = (n == 7) || (n == 18) || (n == 19);
      tick();
      if (n <= 18) begin
        exp_p = 1'b0;
        for (int k = 0; k < 3; k++)
          if (n >= 4 + k * 6 && n <= 5 + k * 6) exp_p = 1'b1;
        exp_b = (n <= 17);
        exp_d = (n == 18);
        exp_i = (n >= 15) ? 8'd2 : (n >= 9) ? 8'd1 : 8'd0;
      end else begin
        // second run accepted at edge 19, zero clamps, active-low
        exp_p = !((n - 19 == 1) || (n - 19 == 3));
        exp_b = (n - 19 >= 1) && (n - 19 <= 3);
        exp_d = (n - 19 == 4);
        exp_i = (n - 19 >= 2) ? 8'd1 : 8'd0;
      end
      chk($sformatf("train%0d.pulse", n), pulse, exp_p);
      chk($sformatf("train%0d.busy", n), busy, exp_b);
      chk($sformatf("train%0d.done", n), done, exp_d);
      chk($sformatf("train%0d.index", n), pulse_index, exp_i);
    end
    start = 1'b0;

    // start with abort in idle: nothing starts, idle level stays high after active-low run
    set_cfg(16'd0, 16'd3, 16'd1, 8'd1, 1'b1);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk($sformatf("sa%0d.busy", n), busy, 0);
      chk($sformatf("sa%0d.pulse", n), pulse, 1);
    end

    // Infinite mode D=1 W=1 G=1, abort sampled at relative edge 41
    set_cfg(16'd1, 16'd1, 16'd1, 8'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      abort = (n == 41);
      tick();
      abort = 1'b0;
      exp_p = (n >= 2) && (n <= 40) && (n % 2 == 0);
      exp_b = (n <= 40);
      chk($sformatf("inf%0d.pulse", n), pulse, exp_p);
      chk($sformatf("inf%0d.busy", n), busy, exp_b);
      chk($sformatf("inf%0d.done", n), done, 0);
      if (n == 40 || n == 45) chk($sformatf("inf%0d.index", n), pulse_index, 19);
    end

    // Infinite index wrap D=0 W=1 G=1
    set_cfg(16'd0, 16'd1, 16'd1, 8'd0, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 512; n++) begin
      tick();
      if (n == 511) chk("wrap.index255", pulse_index, 255);
      if (n == 512) begin
        chk("wrap.index0", pulse_index, 0);
        chk("wrap.busy", busy, 1);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wrap.abort.busy", busy, 0);
    chk("wrap.abort.pulse", pulse, 0);
    chk("wrap.abort.index", pulse_index, 0);
    tick();
    chk("wrap.abort.done", done, 0);

    // Async reset in the middle of an active pulse
    set_cfg(16'd2, 16'd5, 16'd1, 8'd1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("ar.pre.pulse", pulse, 1);
    chk("ar.pre.busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar.pulse", pulse, 0);
    chk("ar.busy", busy, 0);
    chk("ar.index", pulse_index, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("ar%0d.state", n), {pulse, busy, done}, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
